// File: rtl/wb_wbuf_pkg.sv
// Shared types for the posted-write buffer: controller states and the buffered entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_wbuf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int ENTRY_W = 68;

    // One buffered write: address, byte selects, data (68 bits total).
    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } entry_t;

endpackage

// File: rtl/wb_wbuf_fifo.sv
// Synchronous FIFO holding buffered write entries; head is a combinational read of the oldest slot.
// Latency: a push is visible at head on the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty; neither is guarded here.
// Ports: clk/rst (async active-high); push/push_dat write side; pop/head read side; full, empty, count status.
module wb_wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (!push && pop)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/wb_write_buffer.sv
// Posted-write buffer between the core Wishbone master and main memory; writes ack on entry, reads wait for drain.
// Latency: write ack 1 cycle after accept; read ack 4 cycles after accept with a 2-cycle memory, from an empty buffer.
// Backpressure: writes stall (no ack) while the FIFO is full; reads stall until the FIFO is empty and memory idle.
// Ports: i_s_* / o_s_* core-side slave port; o_m_* / i_m_* memory-side master port; o_empty idle status.
module wb_write_buffer
    import wb_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_s_adr,
    input  logic [3:0]  i_s_sel,
    input  logic        i_s_we,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_cyc,
    input  logic        i_s_stb,
    output logic [31:0] o_s_dat,
    output logic        o_s_ack,
    output logic        o_s_err,
    output logic [31:0] o_m_adr,
    output logic [3:0]  o_m_sel,
    output logic        o_m_we,
    output logic [31:0] o_m_dat,
    output logic        o_m_cyc,
    output logic        o_m_stb,
    input  logic [31:0] i_m_dat,
    input  logic        i_m_ack,
    input  logic        i_m_err,
    output logic        o_empty
);

    state_t         state;
    entry_t         wr_entry;
    entry_t         head_entry;
    entry_t         next_entry;
    logic [PTR_W:0] count;
    logic           full;
    logic           empty;
    logic           accept;
    logic           push;
    logic           pop;
    logic           rd_start;
    logic           rd_done;
    logic           err_sticky;
    logic           err_report;

    // !o_s_ack keeps a master that holds stb through its ack cycle from being accepted twice.
    assign accept     = i_s_stb && i_s_cyc && !o_s_ack;
    // full is the registered count, so a same-cycle pop never makes room for a push.
    assign push       = accept && i_s_we && !full;
    assign pop        = (state == DRAIN) && (i_m_ack || i_m_err);
    assign rd_start   = accept && !i_s_we && empty && (state == IDLE);
    assign rd_done    = (state == READ) && (i_m_ack || i_m_err);
    assign err_report = push || rd_done;
    assign wr_entry   = '{adr: i_s_adr, sel: i_s_sel, dat: i_s_dat};
    // With an empty FIFO the entry being pushed is about to become the head, so start
    // draining it straight away instead of waiting a cycle for count to update.
    assign next_entry = empty ? wr_entry : head_entry;
    assign o_empty    = (count == '0) && (state == IDLE);

    wb_wbuf_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (push),
        .push_dat (wr_entry),
        .pop      (pop),
        .head     (head_entry),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            err_sticky <= 1'b0;
            o_s_dat    <= '0;
            o_s_ack    <= 1'b0;
            o_s_err    <= 1'b0;
            o_m_adr    <= '0;
            o_m_sel    <= '0;
            o_m_we     <= 1'b0;
            o_m_dat    <= '0;
            o_m_cyc    <= 1'b0;
            o_m_stb    <= 1'b0;
        end else begin
            o_s_ack <= 1'b0;
            o_s_err <= 1'b0;

            // A drain error raised on the same edge as a core ack is held for the following ack.
            err_sticky <= (err_sticky && !err_report) || (pop && i_m_err);

            if (push) begin
                o_s_ack <= 1'b1;
                o_s_err <= err_sticky;
            end

            case (state)
                IDLE: begin
                    // Draining takes priority over a waiting read.
                    if (!empty || push) begin
                        state   <= DRAIN;
                        o_m_adr <= next_entry.adr;
                        o_m_sel <= next_entry.sel;
                        o_m_dat <= next_entry.dat;
                        o_m_we  <= 1'b1;
                        o_m_cyc <= 1'b1;
                        o_m_stb <= 1'b1;
                    end else if (rd_start) begin
                        state   <= READ;
                        o_m_adr <= i_s_adr;
                        o_m_sel <= i_s_sel;
                        o_m_dat <= '0;
                        o_m_we  <= 1'b0;
                        o_m_cyc <= 1'b1;
                        o_m_stb <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Dropping stb here guarantees an idle gap between memory writes.
                    if (pop) begin
                        state   <= IDLE;
                        o_m_we  <= 1'b0;
                        o_m_cyc <= 1'b0;
                        o_m_stb <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_done) begin
                        state   <= RESP;
                        o_m_cyc <= 1'b0;
                        o_m_stb <= 1'b0;
                        o_s_dat <= i_m_dat;
                        o_s_ack <= i_m_ack;
                        o_s_err <= i_m_err || err_sticky;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
